// File: rtl/bc_mem_responder.sv
// Word-addressed main memory that serves the basic computer's controller.
// Each request gets a one-cycle ACK after LATENCY wait states. A preload port fills the array while the block is idle.
module bc_mem_responder #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  REQ,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [WIDTH-1:0]      WDATA,
    input  logic                  LD_EN,
    input  logic [ADDR_WIDTH-1:0] LD_ADDR,
    input  logic [WIDTH-1:0]      LD_DATA,
    output logic                  ACK,
    output logic [WIDTH-1:0]      RDATA,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic [WIDTH-1:0]        rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic [WIDTH-1:0]        fwd_rdata_s;

    logic [WIDTH-1:0]        mem [DEPTH];

    // Zero-latency read must see a preload issued on the same accepting edge.
    always_comb begin
        if (LD_EN && (LD_ADDR == ADDR)) begin
            fwd_rdata_s = LD_DATA;
        end else begin
            fwd_rdata_s = mem[ADDR];
        end
    end

    // Next-state, request latch and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    addr_d  = ADDR;
                    we_d    = WE;
                    wdata_d = WDATA;
                    cnt_d   = LAT;
                    if (LAT == 4'd0) begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        if (!WE) begin
                            rdata_d = fwd_rdata_s;
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem[addr_q];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers; the array itself is deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Writes commit leaving RESP. Preloads land only while idle, so the two never collide.
    always_ff @(posedge clk) begin
        if ((state_q == ST_RESP) && we_q) begin
            mem[addr_q] <= wdata_q;
        end else if ((state_q == ST_IDLE) && LD_EN) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

    assign ACK   = ack_q;
    assign RDATA = rdata_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_bc_mem_responder.sv
// Bench for bc_mem_responder: unit 0 runs with LATENCY=2 and unit 1 with LATENCY=0.
// Both are checked against a plain array model of memory contents and ACK timing.
module tb_bc_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_s     [2];
    logic        we_s      [2];
    logic [11:0] addr_s    [2];
    logic [15:0] wdata_s   [2];
    logic        ld_en_s   [2];
    logic [11:0] ld_addr_s [2];
    logic [15:0] ld_data_s [2];

    logic        ack_a, ack_b, busy_a, busy_b;
    logic [15:0] rdata_a, rdata_b;

    logic [15:0] model   [2][4096];
    logic [15:0] last_rd [2];
    int          checks = 0;
    int          errors = 0;

    bc_mem_responder #(.WIDTH(16), .ADDR_WIDTH(12), .DEPTH(4096), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .REQ(req_s[0]), .WE(we_s[0]), .ADDR(addr_s[0]),
        .WDATA(wdata_s[0]), .LD_EN(ld_en_s[0]), .LD_ADDR(ld_addr_s[0]), .LD_DATA(ld_data_s[0]),
        .ACK(ack_a), .RDATA(rdata_a), .BUSY(busy_a)
    );

    bc_mem_responder #(.WIDTH(16), .ADDR_WIDTH(12), .DEPTH(4096), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .REQ(req_s[1]), .WE(we_s[1]), .ADDR(addr_s[1]),
        .WDATA(wdata_s[1]), .LD_EN(ld_en_s[1]), .LD_ADDR(ld_addr_s[1]), .LD_DATA(ld_data_s[1]),
        .ACK(ack_b), .RDATA(rdata_b), .BUSY(busy_b)
    );

    function automatic logic get_ack(input int u);
        return (u == 0) ? ack_a : ack_b;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [15:0] get_rdata(input int u);
        return (u == 0) ? rdata_a : rdata_b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int u, input logic [11:0] a, input logic [15:0] d);
        ld_addr_s[u] = a;
        ld_data_s[u] = d;
        ld_en_s[u]   = 1'b1;
        model[u][a]  = d;
        step();
        ld_en_s[u] = 1'b0;
    endtask

    // One full transaction. drop: change the request inputs during WAIT. mid_ld: pulse LD_EN during WAIT.
    // hold: leave REQ high after the ACK cycle.
    task automatic txn(input int u, input bit w, input logic [11:0] a, input logic [15:0] d,
                       input bit drop, input bit mid_ld, input bit hold);
        int          k;
        int          lat;
        logic [15:0] exp;
        lat        = (u == 0) ? 2 : 0;
        exp        = model[u][a];
        req_s[u]   = 1'b1;
        we_s[u]    = w;
        addr_s[u]  = a;
        wdata_s[u] = d;
        k = 0;
        do begin
            step();
            k++;
            if (k == 1) begin
                chk("busy_first", 32'(get_busy(u)), 32'd1);
                ld_en_s[u] = mid_ld;
                if (drop) begin
                    req_s[u]   = 1'b0;
                    addr_s[u]  = a + 12'd1;
                    we_s[u]    = 1'b1;
                    wdata_s[u] = 16'hDEAD;
                end
            end
        end while (!get_ack(u) && k < 40);
        ld_en_s[u] = 1'b0;
        chk("ack_cycle", 32'(k), 32'(lat + 1));
        if (!w) begin
            chk("rdata_read", 32'(get_rdata(u)), 32'(exp));
            last_rd[u] = exp;
        end else begin
            chk("rdata_on_write", 32'(get_rdata(u)), 32'(last_rd[u]));
            model[u][a] = d;
        end
        if (!hold) begin
            req_s[u] = 1'b0;
            step();
            chk("ack_after", 32'(get_ack(u)), 32'd0);
            chk("busy_after", 32'(get_busy(u)), 32'd0);
        end
    endtask

    initial begin
        int          k;
        logic [11:0] ra;
        logic [11:0] la;
        logic [15:0] rd;
        logic [15:0] ld;
        bit          rw;
        for (int u = 0; u < 2; u++) begin
            req_s[u] = 1'b0; we_s[u] = 1'b0; addr_s[u] = 12'd0; wdata_s[u] = 16'd0;
            ld_en_s[u] = 1'b0; ld_addr_s[u] = 12'd0; ld_data_s[u] = 16'd0;
            last_rd[u] = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_rdata_b", 32'(rdata_b), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic read with two wait states, then write followed by read-after-write.
        preload(0, 12'h010, 16'h7A5C);
        txn(0, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b1, 12'h0FF, 16'h1234, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 12'h0FF, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Zero latency, including both ends of the address range.
        preload(1, 12'hFFF, 16'hBEEF);
        preload(1, 12'h000, 16'h0001);
        txn(1, 1'b0, 12'hFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        txn(1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Request inputs change during WAIT; the original read still completes.
        preload(0, 12'h040, 16'h4444);
        preload(0, 12'h041, 16'h4141);
        txn(0, 1'b0, 12'h040, 16'h0000, 1'b1, 1'b0, 1'b0);
        txn(0, 1'b0, 12'h041, 16'h0000, 1'b0, 1'b0, 1'b0);

        // REQ held through ACK: a second read is accepted in the following idle cycle.
        txn(0, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b0, 1'b1);
        addr_s[0] = 12'h041;
        k = 0;
        do begin
            step();
            k++;
            if (k == 1) begin
                chk("b2b_idle_busy", 32'(busy_a), 32'd0);
                chk("b2b_idle_ack", 32'(ack_a), 32'd0);
            end
            if (k == 2) req_s[0] = 1'b0;
        end while (!ack_a && k < 40);
        chk("b2b_ack_cycle", 32'(k), 32'd4);
        chk("b2b_rdata", 32'(rdata_a), 32'h4141);
        last_rd[0] = 16'h4141;
        step();

        // Reset during WAIT drops a pending write.
        preload(0, 12'h020, 16'h5555);
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 12'h020; wdata_s[0] = 16'hAAAA;
        step();
        chk("pre_rst_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        chk("mid_rst_rdata", 32'(rdata_a), 32'd0);
        req_s[0] = 1'b0;
        step();
        rst_n = 1'b1;
        last_rd[0] = 16'd0;
        last_rd[1] = 16'd0;
        chk("mid_rst_rdata_b", 32'(rdata_b), 32'd0);
        step();
        txn(0, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Preload together with a write to the same address: the request data wins.
        ld_addr_s[0] = 12'h030; ld_data_s[0] = 16'h1111; ld_en_s[0] = 1'b1;
        model[0][12'h030] = 16'h1111;
        txn(0, 1'b1, 12'h030, 16'h2222, 1'b0, 1'b0, 1'b0);
        txn(0, 1'b0, 12'h030, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Preload together with a read of the same address, for both latencies.
        preload(1, 12'h050, 16'h0000);
        ld_addr_s[1] = 12'h050; ld_data_s[1] = 16'h5A5A; ld_en_s[1] = 1'b1;
        model[1][12'h050] = 16'h5A5A;
        txn(1, 1'b0, 12'h050, 16'h0000, 1'b0, 1'b0, 1'b0);
        ld_addr_s[0] = 12'h051; ld_data_s[0] = 16'h3C3C; ld_en_s[0] = 1'b1;
        model[0][12'h051] = 16'h3C3C;
        txn(0, 1'b0, 12'h051, 16'h0000, 1'b0, 1'b0, 1'b0);

        // LD_EN while busy is ignored.
        preload(0, 12'h060, 16'h6060);
        preload(0, 12'h061, 16'h0610);
        ld_addr_s[0] = 12'h061; ld_data_s[0] = 16'hFFFF;
        txn(0, 1'b0, 12'h060, 16'h0000, 1'b0, 1'b1, 1'b0);
        txn(0, 1'b0, 12'h061, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the array model on a small address window.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 16; i++) begin
                preload(u, 12'h100 + 12'(i), 16'($urandom));
            end
            for (int i = 0; i < 30; i++) begin
                rw = 1'($urandom_range(0, 1));
                ra = 12'h100 + 12'($urandom_range(0, 15));
                rd = 16'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    la = 12'h100 + 12'($urandom_range(0, 15));
                    ld = 16'($urandom);
                    ld_addr_s[u] = la; ld_data_s[u] = ld; ld_en_s[u] = 1'b1;
                    model[u][la] = ld;
                end
                txn(u, rw, ra, rd, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bc_mem_responder.md
Name: bc_mem_responder

Overview:
- Main-memory responder for the basic computer. It is the other end of the controller's memory interface: the controller issues read requests (fetch, indirect, operand DR <- M[AR]) and write requests (M[AR] <- data), and this block serves them.
- It holds a word-addressed array and answers each request with a one-cycle ACK after a programmable number of wait states.
- A preload port fills program and data while the block is idle.

Parameters:
- WIDTH, 16, data word width.
- ADDR_WIDTH, 12, address width; matches AR.
- DEPTH, 4096, number of words; must equal 2**ADDR_WIDTH.
- LATENCY, 2, wait states between request acceptance and ACK; allowed range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- REQ  input  1  memory request; held high by the requester until ACK.
- WE  input  1  1 = write, 0 = read; sampled with REQ.
- ADDR  input  ADDR_WIDTH  word address (AR).
- WDATA  input  WIDTH  write data; sampled with REQ.
- LD_EN  input  1  preload strobe.
- LD_ADDR  input  ADDR_WIDTH  preload address.
- LD_DATA  input  WIDTH  preload data.
- ACK  output  1  single-cycle completion pulse.
- RDATA  output  WIDTH  read data; valid while ACK=1 for a read.
- BUSY  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset: one clock, asynchronous, active-low.
  - rst_n=0 immediately forces state=IDLE, ACK=0, BUSY=0, RDATA=0, wait counter=0, latched request cleared.
  - Array contents are NOT reset.
- States: IDLE, WAIT, RESP.
- IDLE with REQ=1 at an edge:
  - Latch ADDR, WE, WDATA.
  - Load the counter with LATENCY.
  - Go to WAIT if LATENCY>0, else go to RESP.
- WAIT: the counter decrements each edge. Transition to RESP on the edge where the counter goes 1 -> 0.
- RESP: lasts exactly one cycle. ACK=1 during it, then unconditionally return to IDLE.
  - Read: RDATA = mem[latched ADDR], registered on entry to RESP.
  - Write: mem[latched ADDR] <= latched WDATA on the edge leaving RESP (commit point).
  - RDATA is unchanged by writes.
  - RDATA holds the last read value until the next read ACK.
- Latency: ACK is high in cycle N+LATENCY+1, where N is the cycle in which REQ is first sampled in IDLE.
- BUSY = (state != IDLE), registered alongside state.
- Request changes while not in IDLE:
  - REQ, ADDR, WE and WDATA are ignored in WAIT and RESP.
  - A dropped REQ does not abort; the transaction completes and ACKs.
- Back-to-back: the requester deasserts REQ in the ACK cycle. If REQ is still high in the IDLE cycle after RESP, a new transaction is accepted with the then-current ADDR, WE and WDATA.
- Read-after-write to the same address returns the new data (the write commits before any later read can reach RESP).
- Address wrap: ADDR is used modulo DEPTH; no out-of-range condition exists.
- Preload:
  - LD_EN=1 in IDLE writes mem[LD_ADDR] <= LD_DATA at that edge.
  - LD_EN is ignored outside IDLE; no ACK is produced.
  - LD_EN and REQ both high in IDLE: the preload is performed and the request is also accepted.
  - If that request is a write to LD_ADDR, the request data wins (it commits later).
  - If it is a read of LD_ADDR, the read returns LD_DATA.
- Reset mid-operation: the transaction is dropped and no ACK is produced. A write not yet past its commit edge leaves the array unchanged.

Test Plan:
- Preload mem[0x010]=0x7A5C, LATENCY=2. Read ADDR=0x010 with REQ in cycle 0 -> BUSY=1 from cycle 1, ACK=1 and RDATA=0x7A5C only in cycle 3, BUSY=0 in cycle 4.
- Write 0x1234 to 0x0FF, then immediately read 0x0FF -> second ACK returns RDATA=0x1234; RDATA unchanged during the write ACK.
- LATENCY=0: read of preloaded mem[0xFFF]=0xBEEF -> ACK in cycle 1 with 0xBEEF. Then ADDR=0x000 after preloading 0x0001 -> 0x0001 (wrap boundary).
- Drop REQ and change ADDR during WAIT -> ACK still at the original latency, data taken from the original address. Hold REQ through ACK -> a second transaction starts and a second ACK appears LATENCY+1 cycles later.
- Write 0xAAAA to 0x020 (previously 0x5555), with rst_n pulsed low in the WAIT state -> no ACK, ACK=0 and BUSY=0 immediately; a subsequent read of 0x020 returns 0x5555.
- LD_EN with LD_ADDR=0x030, LD_DATA=0x1111, together with a REQ write of 0x2222 to 0x030 -> a later read returns 0x2222. LD_EN asserted during WAIT -> array unchanged.
